// File: rtl/parallel_transfer_pipe.sv
// Parametrised WIDTH x DEPTH register chain with shift and broadcast transfer modes,
// per-stage valid bits and a registered fill count / full flag.
module parallel_transfer_pipe #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         mode,
  input  logic                         clr,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         in_valid,
  output logic [WIDTH*DEPTH-1:0]       stages,
  output logic [DEPTH-1:0]             stage_valid,
  output logic [WIDTH-1:0]             data_out,
  output logic                         out_valid,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic                         full
);

  localparam int FW = $clog2(DEPTH+1);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  logic [WIDTH*DEPTH-1:0] stages_q, stages_d;
  logic [DEPTH-1:0]       stage_valid_q, stage_valid_d;
  logic [FW-1:0]          fill_q, fill_d;
  logic                   full_q, full_d;

  // fill is tracked incrementally so it stays equal to popcount(stage_valid) every cycle
  always_comb begin
    stages_d      = stages_q;
    stage_valid_d = stage_valid_q;
    fill_d        = fill_q;
    if (clr) begin
      stage_valid_d = '0;
      fill_d        = '0;
    end else if (en) begin
      if (mode) begin
        stages_d      = {DEPTH{data_in}};
        stage_valid_d = {DEPTH{in_valid}};
        fill_d        = in_valid ? FILL_MAX : '0;
      end else begin
        stages_d      = {stages_q[WIDTH*(DEPTH-1)-1:0], data_in};
        stage_valid_d = {stage_valid_q[DEPTH-2:0], in_valid};
        fill_d        = fill_q + FW'(in_valid) - FW'(stage_valid_q[DEPTH-1]);
      end
    end
    full_d = (fill_d == FILL_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages_q      <= '0;
      stage_valid_q <= '0;
      fill_q        <= '0;
      full_q        <= 1'b0;
    end else begin
      stages_q      <= stages_d;
      stage_valid_q <= stage_valid_d;
      fill_q        <= fill_d;
      full_q        <= full_d;
    end
  end

  assign stages      = stages_q;
  assign stage_valid = stage_valid_q;
  assign data_out    = stages_q[WIDTH*(DEPTH-1) +: WIDTH];
  assign out_valid   = stage_valid_q[DEPTH-1];
  assign fill        = fill_q;
  assign full        = full_q;

endmodule

// File: tb/tb_parallel_transfer_pipe.sv
// Bench for parallel_transfer_pipe: a DEPTH=4 and a DEPTH=2 instance share one stimulus
// stream; a behavioural model pushes expected state to a queue that is popped after each edge.
module tb_parallel_transfer_pipe;

  logic        clk = 1'b0;
  logic        rst, en, mode, clr, in_valid;
  logic [3:0]  data_in;

  logic [15:0] s4;
  logic [3:0]  sv4, do4;
  logic        ov4, full4;
  logic [2:0]  fill4;

  logic [7:0]  s2;
  logic [1:0]  sv2, fill2;
  logic [3:0]  do2;
  logic        ov2, full2;

  int total = 0;
  int bad   = 0;

  parallel_transfer_pipe #(.WIDTH(4), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr),
    .data_in(data_in), .in_valid(in_valid),
    .stages(s4), .stage_valid(sv4), .data_out(do4), .out_valid(ov4),
    .fill(fill4), .full(full4)
  );

  parallel_transfer_pipe #(.WIDTH(4), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr),
    .data_in(data_in), .in_valid(in_valid),
    .stages(s2), .stage_valid(sv2), .data_out(do2), .out_valid(ov2),
    .fill(fill2), .full(full2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s4;
    logic [3:0]  sv4;
    logic [2:0]  f4;
    logic        fu4;
    logic [7:0]  s2;
    logic [1:0]  sv2;
    logic [1:0]  f2;
    logic        fu2;
  } exp_t;

  exp_t exp_q[$];

  logic [3:0] m4 [4];
  logic       mv4[4];
  logic [3:0] m2 [2];
  logic       mv2[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin m4[k] = 4'h0; mv4[k] = 1'b0; end
    for (int k = 0; k < 2; k++) begin m2[k] = 4'h0; mv2[k] = 1'b0; end
  endtask

  task automatic model_update(input logic e, input logic m, input logic c,
                              input logic [3:0] d, input logic v);
    if (c) begin
      for (int k = 0; k < 4; k++) mv4[k] = 1'b0;
      for (int k = 0; k < 2; k++) mv2[k] = 1'b0;
    end else if (e && m) begin
      for (int k = 0; k < 4; k++) begin m4[k] = d; mv4[k] = v; end
      for (int k = 0; k < 2; k++) begin m2[k] = d; mv2[k] = v; end
    end else if (e) begin
      for (int k = 3; k > 0; k--) begin m4[k] = m4[k-1]; mv4[k] = mv4[k-1]; end
      m4[0] = d; mv4[0] = v;
      m2[1] = m2[0]; mv2[1] = mv2[0];
      m2[0] = d; mv2[0] = v;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    int   c4 = 0;
    int   c2 = 0;
    for (int k = 0; k < 4; k++) begin
      e.s4[k*4 +: 4] = m4[k];
      e.sv4[k]       = mv4[k];
      c4 += int'(mv4[k]);
    end
    for (int k = 0; k < 2; k++) begin
      e.s2[k*4 +: 4] = m2[k];
      e.sv2[k]       = mv2[k];
      c2 += int'(mv2[k]);
    end
    e.f4  = 3'(c4);
    e.fu4 = (c4 == 4);
    e.f2  = 2'(c2);
    e.fu2 = (c2 == 2);
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    total++;
    assert (exp_q.size() > 0) else begin
      bad++;
      $error("[TB] FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_s4"},    32'(s4),    32'(e.s4));
      chk({tag, "_sv4"},   32'(sv4),   32'(e.sv4));
      chk({tag, "_fill4"}, 32'(fill4), 32'(e.f4));
      chk({tag, "_full4"}, 32'(full4), 32'(e.fu4));
      chk({tag, "_do4"},   32'(do4),   32'(e.s4[15:12]));
      chk({tag, "_ov4"},   32'(ov4),   32'(e.sv4[3]));
      chk({tag, "_s2"},    32'(s2),    32'(e.s2));
      chk({tag, "_sv2"},   32'(sv2),   32'(e.sv2));
      chk({tag, "_fill2"}, 32'(fill2), 32'(e.f2));
      chk({tag, "_full2"}, 32'(full2), 32'(e.fu2));
      chk({tag, "_do2"},   32'(do2),   32'(e.s2[7:4]));
      chk({tag, "_ov2"},   32'(ov2),   32'(e.sv2[1]));
    end
  endtask

  task automatic applyStimulus(input string tag, input logic e, input logic m, input logic c,
                               input logic [3:0] d, input logic v);
    en = e; mode = m; clr = c; data_in = d; in_valid = v;
    model_update(e, m, c, d, v);
    push_expected();
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; clr = 1'b0; data_in = 4'h0; in_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_s4", 32'(s4), 32'h0);
    chk("reset_fill4", 32'(fill4), 32'h0);
    chk("reset_s2", 32'(s2), 32'h0);
    chk("reset_full2", 32'(full2), 32'h0);
    rst = 1'b0;

    // shift 1,2,3,4 then one more to exercise drop-at-full
    applyStimulus("sh1", 1, 0, 0, 4'h1, 1);
    applyStimulus("sh2", 1, 0, 0, 4'h2, 1);
    applyStimulus("sh3", 1, 0, 0, 4'h3, 1);
    applyStimulus("sh4", 1, 0, 0, 4'h4, 1);
    chk("shift_stages", 32'(s4), 32'h1234);
    chk("shift_fill", 32'(fill4), 32'd4);
    chk("shift_full", 32'(full4), 32'd1);
    chk("shift_dout", 32'(do4), 32'h1);
    applyStimulus("sh5_full", 1, 0, 0, 4'h5, 1);
    chk("drop_fill", 32'(fill4), 32'd4);

    // asynchronous reset mid-stream on the DEPTH=2 pattern A5
    applyStimulus("ldA", 1, 0, 0, 4'hA, 1);
    applyStimulus("ld5", 1, 0, 0, 4'h5, 1);
    chk("pre_rst_s2", 32'(s2), 32'hA5);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_s2", 32'(s2), 32'h0);
    chk("async_rst_sv2", 32'(sv2), 32'h0);
    chk("async_rst_fill2", 32'(fill2), 32'h0);
    chk("async_rst_full2", 32'(full2), 32'h0);
    chk("async_rst_s4", 32'(s4), 32'h0);
    rst = 1'b0;

    applyStimulus("bc7", 1, 1, 0, 4'h7, 1);
    chk("bcast_s2", 32'(s2), 32'h77);
    chk("bcast_fill2", 32'(fill2), 32'd2);
    chk("bcast_full2", 32'(full2), 32'd1);
    applyStimulus("bc7_inv", 1, 1, 0, 4'h7, 0);
    chk("bcast_inv_fill2", 32'(fill2), 32'd0);
    chk("bcast_inv_s2", 32'(s2), 32'h77);

    // enable gaps must not move the word
    applyStimulus("ldC", 1, 0, 0, 4'hC, 1);
    applyStimulus("hold1", 0, 0, 0, 4'h1, 1);
    applyStimulus("hold2", 0, 1, 0, 4'h2, 0);
    applyStimulus("hold3", 0, 0, 0, 4'h3, 1);
    chk("hold_fill", 32'(fill4), 32'd1);
    applyStimulus("mv1", 1, 0, 0, 4'h0, 0);
    applyStimulus("mv2", 1, 0, 0, 4'h0, 0);
    applyStimulus("mv3", 1, 0, 0, 4'h0, 0);
    chk("hold_dout", 32'(do4), 32'hC);
    chk("hold_ov", 32'(ov4), 32'd1);

    applyStimulus("f5", 1, 0, 0, 4'h5, 1);
    applyStimulus("f6", 1, 0, 0, 4'h6, 1);
    applyStimulus("f7", 1, 0, 0, 4'h7, 1);
    applyStimulus("f8", 1, 0, 0, 4'h8, 1);
    applyStimulus("clr", 1, 0, 1, 4'hF, 1);
    chk("clr_stages", 32'(s4), 32'h5678);
    chk("clr_sv", 32'(sv4), 32'h0);
    chk("clr_fill", 32'(fill4), 32'd0);

    applyStimulus("ms1", 1, 0, 0, 4'h1, 1);
    applyStimulus("ms2", 1, 0, 0, 4'h2, 1);
    applyStimulus("ms_bc9", 1, 1, 0, 4'h9, 1);
    chk("ms_bc_stages", 32'(s4), 32'h9999);
    chk("ms_bc_fill", 32'(fill4), 32'd4);
    applyStimulus("ms_shE", 1, 0, 0, 4'hE, 0);
    chk("ms_stages", 32'(s4), 32'h999E);
    chk("ms_sv", 32'(sv4), 32'b1110);
    chk("ms_fill", 32'(fill4), 32'd3);

    for (int i = 0; i < 40; i++) begin
      applyStimulus("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 9) == 0), 4'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
